// File: rtl/mem_responder_if.sv
// Bus bundle between the 6502 core memory mux and the memory responder.
// The core side is the master: it issues requests and consumes the byte stream.
// The responder side is the slave: it returns read data, irq and the FIFO head.
interface mem_responder_if;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
  // Access type: 0 = write, 1 = read
  typedef logic        mw_t;

  logic  req;
  addr_t addr;
  mw_t   mw;
  data_t wdata;
  data_t rdata;
  logic  rvalid;
  logic  irq;
  data_t out_data;
  logic  out_valid;
  logic  out_ready;

  modport slave (
    input  req, addr, mw, wdata, out_ready,
    output rdata, rvalid, irq, out_data, out_valid
  );

  modport master (
    output req, addr, mw, wdata, out_ready,
    input  rdata, rvalid, irq, out_data, out_valid
  );
endinterface

// File: rtl/mem_responder.sv
// Memory responder: RAM at 0x0000, interval timer with irq, 4-deep byte output FIFO.
// Latency: reads return registered data one cycle after the sampling edge; writes land on that edge.
// Backpressure: requests never stall; FIFO pushes while full are dropped and flagged in OVF.
module mem_responder #(
  parameter int unsigned RAM_AW  = 10,
  parameter logic [15:0] IO_BASE = 16'hD000
) (
  input logic          clk,
  input logic          rst_n,
  mem_responder_if.slave bus
);
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam logic        MW_READ   = 1'b1;

  // ---------------- address decode ----------------
  logic [16:0]       addr_x;
  logic [16:0]       io_lo;
  logic [16:0]       io_hi;
  logic              is_ram;
  logic              is_io;
  logic [2:0]        off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr;
  logic              rd;

  // 17-bit compares so an IO window near the top of memory cannot wrap
  assign addr_x  = {1'b0, bus.addr};
  assign io_lo   = {1'b0, IO_BASE};
  assign io_hi   = io_lo + 17'd7;
  assign is_ram  = addr_x < 17'(RAM_DEPTH);
  assign is_io   = (addr_x >= io_lo) && (addr_x <= io_hi);
  // low 3 bits of (addr - IO_BASE) only depend on the low 3 bits of each
  assign off     = bus.addr[2:0] - IO_BASE[2:0];
  assign ram_idx = bus.addr[RAM_AW-1:0];
  assign wr      = bus.req && (bus.mw != MW_READ);
  assign rd      = bus.req && (bus.mw == MW_READ);

  logic io_wr;
  assign io_wr = wr && is_io;

  // ---------------- RAM ----------------
  logic [7:0] ram [RAM_DEPTH];

  // RAM write port; contents are intentionally left unreset
  always_ff @(posedge clk) begin
    if (wr && is_ram) ram[ram_idx] <= bus.wdata;
  end

  // ---------------- timer ----------------
  logic [15:0] tmr_rld;
  logic [15:0] tmr_cnt;
  logic        tmr_en;
  logic        tmr_auto;
  logic        tmr_ie;
  logic        tmr_exp;
  logic        ctrl_wr;
  logic        expire;

  assign ctrl_wr = io_wr && (off == 3'd2);
  // a CTRL write overrides the tick of that cycle, so it cannot also expire
  assign expire  = tmr_en && (tmr_cnt == 16'd0) && !ctrl_wr;

  // Reload/control registers, down-counter and sticky expiry flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_rld  <= '0;
      tmr_cnt  <= '0;
      tmr_en   <= 1'b0;
      tmr_auto <= 1'b0;
      tmr_ie   <= 1'b0;
      tmr_exp  <= 1'b0;
    end else begin
      if (io_wr && (off == 3'd0)) tmr_rld[7:0]  <= bus.wdata;
      if (io_wr && (off == 3'd1)) tmr_rld[15:8] <= bus.wdata;

      if (ctrl_wr) begin
        tmr_en   <= bus.wdata[0];
        tmr_auto <= bus.wdata[1];
        tmr_ie   <= bus.wdata[2];
        if (bus.wdata[0]) tmr_cnt <= tmr_rld;
      end else if (tmr_en) begin
        if (tmr_cnt != 16'd0) tmr_cnt <= tmr_cnt - 16'd1;
        else if (tmr_auto)    tmr_cnt <= tmr_rld;
        else                  tmr_en  <= 1'b0;
      end

      // expiry wins over a simultaneous clear-write
      if (expire)                                          tmr_exp <= 1'b1;
      else if (io_wr && (off == 3'd3) && bus.wdata[0])     tmr_exp <= 1'b0;
    end
  end

  assign bus.irq = tmr_exp & tmr_ie;

  // ---------------- output FIFO ----------------
  logic [7:0] fmem [4];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] fcnt;
  logic       ovf;
  logic       f_full;
  logic       f_empty;
  logic       push;
  logic       pop;
  logic       push_ok;
  logic [1:0] rp_nxt;
  logic [2:0] fcnt_nxt;
  logic [7:0] head_nxt;
  logic [7:0] out_data_q;
  logic       out_valid_q;

  assign f_full   = (fcnt == 3'd4);
  assign f_empty  = (fcnt == 3'd0);
  assign push     = io_wr && (off == 3'd4);
  assign pop      = !f_empty && bus.out_ready;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign push_ok  = push && (!f_full || pop);
  assign rp_nxt   = rp + {1'b0, pop};
  assign fcnt_nxt = fcnt + {2'b00, push_ok} - {2'b00, pop};
  // next head is the incoming byte when it lands in the slot the read pointer moves to
  assign head_nxt = (push_ok && (wp == rp_nxt)) ? bus.wdata : fmem[rp_nxt];

  // FIFO storage, pointers, overflow flag and registered head/valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) fmem[i] <= '0;
      wp          <= '0;
      rp          <= '0;
      fcnt        <= '0;
      ovf         <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push_ok) begin
        fmem[wp] <= bus.wdata;
        wp       <= wp + 2'd1;
      end
      rp          <= rp_nxt;
      fcnt        <= fcnt_nxt;
      out_data_q  <= head_nxt;
      out_valid_q <= (fcnt_nxt != 3'd0);
      if (push && !push_ok)          ovf <= 1'b1;
      else if (io_wr && (off == 3'd5)) ovf <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

  // ---------------- read path ----------------
  logic [7:0] rd_mux;
  logic [7:0] rdata_q;
  logic       rvalid_q;

  // Read data selection from pre-update state; unmapped reads return 0xFF
  always_comb begin
    rd_mux = 8'hFF;
    if (is_ram) begin
      rd_mux = ram[ram_idx];
    end else if (is_io) begin
      case (off)
        3'd0: rd_mux = tmr_rld[7:0];
        3'd1: rd_mux = tmr_rld[15:8];
        3'd2: rd_mux = {5'b0, tmr_ie, tmr_auto, tmr_en};
        3'd3: rd_mux = {7'b0, tmr_exp};
        3'd4: rd_mux = 8'h00;
        3'd5: rd_mux = {2'b00, ovf, fcnt, f_empty, f_full};
        3'd6: rd_mux = tmr_cnt[7:0];
        3'd7: rd_mux = tmr_cnt[15:8];
        default: rd_mux = 8'hFF;
      endcase
    end
  end

  // Registered read response; rdata holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd;
      if (rd) rdata_q <= rd_mux;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
endmodule
